// File: rtl/exhaustive_resp_checker_v_pkg.sv
// Shared types and golden truth tables for the exhaustive gate-bench response checker.
package exhaustive_resp_checker_v_pkg;

    // Checker control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Golden outputs: bit k is the expected gate output for input vector k.
    localparam logic [3:0]  TT_OR2 = 4'hE;
    localparam logic [15:0] TT_OR4 = 16'hFFFE;

endpackage

// File: rtl/exhaustive_resp_checker_v_sat_counter_v.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter_v #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CntMax = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, hold at max, or step by one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/exhaustive_resp_checker_v.sv
// Response checker: compares DUT samples against a truth table, tracks coverage,
// counts checks/errors and flags done, pass and timeout.
module exhaustive_resp_checker_v
    import exhaustive_resp_checker_v_pkg::*;
#(
    parameter int unsigned              N_IN        = 4,
    parameter logic [(1 << N_IN)-1:0]   TRUTH_TABLE = TT_OR4,
    parameter int unsigned              CNT_W       = 8,
    parameter int unsigned              TIMEOUT_CYC = 2000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [N_IN-1:0]   i_vec,
    input  logic              i_f,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic              o_cov_full,
    output logic [CNT_W-1:0]  o_chk_cnt,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic [N_IN-1:0]   o_first_err_vec,
    output logic              o_first_err_valid
);

    localparam int unsigned NPat   = 1 << N_IN;
    localparam int unsigned IdleW  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Idle count at which the next empty RUN cycle reaches TIMEOUT_CYC.
    localparam int unsigned IdleLastI = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleLastI);

    state_e            state_q, state_d;
    logic [NPat-1:0]   bitmap_q, bitmap_d;
    logic              cov_full_q, cov_full_d;
    logic              timeout_q, timeout_d;
    logic [N_IN-1:0]   first_err_vec_q, first_err_vec_d;
    logic              first_err_valid_q, first_err_valid_d;

    logic              in_run;
    logic              accept;
    logic              exp_f;
    logic              mismatch;
    logic              complete;
    logic              to_fire;
    logic              idle_clr;
    logic [IdleW-1:0]  idle_cnt;
    logic [CNT_W-1:0]  chk_cnt;
    logic [CNT_W-1:0]  err_cnt;

    assign in_run   = (state_q == ST_RUN);
    // A sample coinciding with start is dropped; start clears everything instead.
    assign accept   = in_run && i_valid && !i_start;
    assign exp_f    = TRUTH_TABLE[i_vec];
    assign mismatch = accept && (i_f != exp_f);
    assign complete = accept && (&bitmap_d);
    // An accept in the same cycle always suppresses the timeout.
    assign to_fire  = (TIMEOUT_CYC != 0) && in_run && !i_valid && !i_start
                      && (idle_cnt == IdleLast);
    assign idle_clr = i_start || accept || !in_run;

    sat_counter_v #(
        .W (CNT_W)
    ) u_chk_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .clr_i (i_start),
        .inc_i (accept),
        .cnt_o (chk_cnt)
    );

    sat_counter_v #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .clr_i (i_start),
        .inc_i (mismatch),
        .cnt_o (err_cnt)
    );

    sat_counter_v #(
        .W (IdleW)
    ) u_idle_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .clr_i (idle_clr),
        .inc_i (in_run),
        .cnt_o (idle_cnt)
    );

    // Coverage bitmap, first-error capture and sticky timeout next-state.
    always_comb begin
        bitmap_d          = bitmap_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        timeout_d         = timeout_q;
        if (i_start) begin
            bitmap_d          = '0;
            first_err_vec_d   = '0;
            first_err_valid_d = 1'b0;
            timeout_d         = 1'b0;
        end else begin
            if (accept) begin
                bitmap_d[i_vec] = 1'b1;
            end
            if (mismatch && !first_err_valid_q) begin
                first_err_vec_d   = i_vec;
                first_err_valid_d = 1'b1;
            end
            if (to_fire) begin
                timeout_d = 1'b1;
            end
        end
        cov_full_d = &bitmap_d;
    end

    // Control state transitions.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end else if (complete || to_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (i_start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= ST_IDLE;
            bitmap_q          <= '0;
            cov_full_q        <= 1'b0;
            timeout_q         <= 1'b0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            bitmap_q          <= bitmap_d;
            cov_full_q        <= cov_full_d;
            timeout_q         <= timeout_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign o_busy            = (state_q == ST_RUN);
    assign o_done            = (state_q == ST_DONE);
    assign o_pass            = o_done && cov_full_q && (err_cnt == '0) && !timeout_q;
    assign o_timeout         = timeout_q;
    assign o_cov_full        = cov_full_q;
    assign o_chk_cnt         = chk_cnt;
    assign o_err_cnt         = err_cnt;
    assign o_first_err_vec   = first_err_vec_q;
    assign o_first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_exhaustive_resp_checker_v.sv
// Directed bench: OR4 truth table, default instance plus a small-counter/short-timeout one.
module tb_exhaustive_resp_checker_v;

    logic       clk;
    logic       rst;
    logic       start;
    logic       valid;
    logic [3:0] vec;
    logic       f;

    logic       a_busy, a_done, a_pass, a_timeout, a_cov_full, a_fev_valid;
    logic [7:0] a_chk, a_err;
    logic [3:0] a_fev;

    logic       b_busy, b_done, b_pass, b_timeout, b_cov_full, b_fev_valid;
    logic [3:0] b_chk, b_err;
    logic [3:0] b_fev;

    int checks = 0;
    int errors = 0;

    logic [15:0] tt = 16'hFFFE;

    exhaustive_resp_checker_v #(
        .N_IN        (4),
        .TRUTH_TABLE (16'hFFFE),
        .CNT_W       (8),
        .TIMEOUT_CYC (2000)
    ) u_dut_a (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_valid           (valid),
        .i_vec             (vec),
        .i_f               (f),
        .o_busy            (a_busy),
        .o_done            (a_done),
        .o_pass            (a_pass),
        .o_timeout         (a_timeout),
        .o_cov_full        (a_cov_full),
        .o_chk_cnt         (a_chk),
        .o_err_cnt         (a_err),
        .o_first_err_vec   (a_fev),
        .o_first_err_valid (a_fev_valid)
    );

    exhaustive_resp_checker_v #(
        .N_IN        (4),
        .TRUTH_TABLE (16'hFFFE),
        .CNT_W       (4),
        .TIMEOUT_CYC (10)
    ) u_dut_b (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_valid           (valid),
        .i_vec             (vec),
        .i_f               (f),
        .o_busy            (b_busy),
        .o_done            (b_done),
        .o_pass            (b_pass),
        .o_timeout         (b_timeout),
        .o_cov_full        (b_cov_full),
        .o_chk_cnt         (b_chk),
        .o_err_cnt         (b_err),
        .o_first_err_vec   (b_fev),
        .o_first_err_valid (b_fev_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one sample for one cycle; valid stays high for back-to-back sends.
    task automatic send(input logic [3:0] v, input logic fv);
        valid = 1'b1;
        vec   = v;
        f     = fv;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        vec   = '0;
        f     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_busy", 32'(a_busy), 0);
        check_eq("rst_done", 32'(a_done), 0);
        check_eq("rst_pass", 32'(a_pass), 0);
        check_eq("rst_chk", 32'(a_chk), 0);
        check_eq("rst_cov", 32'(a_cov_full), 0);
        check_eq("rst_fevv", 32'(a_fev_valid), 0);

        // Idle ignores valid
        send(4'd2, 1'b1);
        valid = 1'b0;
        check_eq("idle_chk", 32'(a_chk), 0);

        // Pass run
        do_start();
        check_eq("run_busy", 32'(a_busy), 1);
        for (int i = 0; i < 16; i++) send(4'(i), tt[i]);
        valid = 1'b0;
        check_eq("pass_chk", 32'(a_chk), 16);
        check_eq("pass_err", 32'(a_err), 0);
        check_eq("pass_cov", 32'(a_cov_full), 1);
        check_eq("pass_done", 32'(a_done), 1);
        check_eq("pass_pass", 32'(a_pass), 1);
        check_eq("pass_busy", 32'(a_busy), 0);
        send(4'd9, 1'b0);
        valid = 1'b0;
        check_eq("done_hold_chk", 32'(a_chk), 16);
        check_eq("done_hold_err", 32'(a_err), 0);

        // Error capture: vec 5 wrong first, vec 0 wrong last
        do_start();
        check_eq("restart_chk", 32'(a_chk), 0);
        check_eq("restart_done", 32'(a_done), 0);
        for (int i = 1; i < 16; i++) send(4'(i), (i == 5) ? 1'b0 : tt[i]);
        send(4'd0, 1'b1);
        valid = 1'b0;
        check_eq("err_cnt", 32'(a_err), 2);
        check_eq("err_chk", 32'(a_chk), 16);
        check_eq("err_fev", 32'(a_fev), 5);
        check_eq("err_fevv", 32'(a_fev_valid), 1);
        check_eq("err_done", 32'(a_done), 1);
        check_eq("err_pass", 32'(a_pass), 0);

        // Duplicates and partial coverage
        do_start();
        for (int i = 0; i < 3; i++) send(4'd3, tt[3]);
        for (int i = 0; i < 16; i++) begin
            if (i != 3 && i != 7) send(4'(i), tt[i]);
        end
        valid = 1'b0;
        check_eq("dup_chk", 32'(a_chk), 17);
        check_eq("dup_cov", 32'(a_cov_full), 0);
        check_eq("dup_done", 32'(a_done), 0);
        check_eq("dup_busy", 32'(a_busy), 1);
        send(4'd7, tt[7]);
        valid = 1'b0;
        check_eq("dup_fin_done", 32'(a_done), 1);
        check_eq("dup_fin_cov", 32'(a_cov_full), 1);
        check_eq("dup_fin_chk", 32'(a_chk), 18);
        check_eq("dup_fin_pass", 32'(a_pass), 1);

        // Timeout on the short-timeout instance
        do_start();
        send(4'd0, tt[0]);
        send(4'd1, tt[1]);
        valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("to_early", 32'(b_timeout), 0);
        check_eq("to_early_busy", 32'(b_busy), 1);
        tick();
        check_eq("to_flag", 32'(b_timeout), 1);
        check_eq("to_done", 32'(b_done), 1);
        check_eq("to_pass", 32'(b_pass), 0);
        do_start();
        check_eq("to_cleared", 32'(b_timeout), 0);
        check_eq("to_restart_busy", 32'(b_busy), 1);

        // Reset mid-run
        for (int i = 0; i < 8; i++) send(4'(i), tt[i]);
        valid = 1'b0;
        check_eq("mid_chk", 32'(a_chk), 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(a_busy), 0);
        check_eq("mid_rst_chk", 32'(a_chk), 0);
        check_eq("mid_rst_cov", 32'(a_cov_full), 0);
        send(4'd4, 1'b0);
        valid = 1'b0;
        check_eq("mid_rst_ignore", 32'(a_chk), 0);
        check_eq("mid_rst_err", 32'(a_err), 0);

        // Start together with valid drops the sample
        start = 1'b1;
        valid = 1'b1;
        vec   = 4'd0;
        f     = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b0;
        check_eq("startv_chk", 32'(a_chk), 0);
        check_eq("startv_err", 32'(a_err), 0);
        check_eq("startv_busy", 32'(a_busy), 1);

        // Start in RUN clears the first-error capture
        send(4'd6, 1'b0);
        valid = 1'b0;
        check_eq("rerun_fevv_set", 32'(a_fev_valid), 1);
        do_start();
        check_eq("rerun_fevv_clr", 32'(a_fev_valid), 0);
        check_eq("rerun_chk", 32'(a_chk), 0);

        // Saturation on the 4-bit instance; vectors 3..7,0..2 cycle, never full coverage
        for (int i = 0; i < 20; i++) send(4'((i + 3) % 8), ~tt[(i + 3) % 8]);
        valid = 1'b0;
        check_eq("sat_chk", 32'(b_chk), 15);
        check_eq("sat_err", 32'(b_err), 15);
        check_eq("sat_fev", 32'(b_fev), 3);
        check_eq("sat_fevv", 32'(b_fev_valid), 1);
        check_eq("sat_wide_err", 32'(a_err), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
